// File: rtl/store_pkg.sv
// Shared definitions for the store merge unit: size encodings, FSM state
// type and the alignment rule that decides whether a store is legal.
package store_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      MRG  = 2'b10,
      WR   = 2'b11
   } state_t;

   // Bytes are always legal, halfwords need an even address, words need
   // a word-aligned address and the reserved size is never legal.
   function automatic logic is_aligned(input logic [1:0] size,
                                       input logic [1:0] off);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~off[0];
         SZ_WORD: ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Little-endian lane insert: drops the narrowed store data into the
// addressed byte or halfword of an existing word.
module lane_merge
   import store_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0: merged[7:0]   = new_data[7:0];
               2'd1: merged[15:8]  = new_data[7:0];
               2'd2: merged[23:16] = new_data[7:0];
               2'd3: merged[31:24] = new_data[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offset[1]) merged[31:16] = new_data[15:0];
            else           merged[15:0]  = new_data[15:0];
         end
         SZ_WORD: merged = new_data;
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/store_merge_unit.sv
// Multicycle store unit for a word-only memory: SW writes directly, SB/SH
// read the target word, merge the new lane and write it back.
module store_merge_unit
   import store_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_data,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              fault
);

   state_t      state;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic [31:0] data_q;
   logic [31:0] merged;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

   // Request payload is plain data: captured on every IDLE request, no reset.
   always_ff @(posedge Clk) begin
      if (state == IDLE && req_valid) begin
         size_q <= req_size;
         off_q  <= req_addr[1:0];
         data_q <= req_data;
      end
   end

   lane_merge u_lane_merge (
      .old_word (mem_rdata),
      .new_data (data_q),
      .size     (size_q),
      .offset   (off_q),
      .merged   (merged)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         fault <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (!is_aligned(req_size, req_addr[1:0])) begin
                     fault <= 1'b1;
                  end else begin
                     mem_addr  <= req_addr[MEM_AW+1:2];
                     req_ready <= 1'b0;
                     busy      <= 1'b1;
                     if (req_size == SZ_WORD) begin
                        mem_wdata <= req_data;
                        mem_wr    <= 1'b1;
                        state     <= WR;
                     end else begin
                        mem_rd <= 1'b1;
                        state  <= RD;
                     end
                  end
               end
            end
            RD: begin
               mem_rd <= 1'b0;
               state  <= MRG;
            end
            // Read data arrives this cycle; merge it straight into the write word.
            MRG: begin
               mem_wdata <= merged;
               mem_wr    <= 1'b1;
               state     <= WR;
            end
            WR: begin
               mem_wr    <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
